wb_ctrl: RTL and testbench
==========================

WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter XLEN, default 32, data width.
REQ-002 Parameter DEPTH, default 4, load-result queue entries (power of two, >=2).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 alu_valid  in  1  ALU result present this cycle; never back-pressured.
REQ-006 alu_rd  in  5  ALU destination register.
REQ-007 alu_data  in  XLEN  ALU result.
REQ-008 ld_valid  in  1  load result offered.
REQ-009 ld_ready  out  1  queue can accept; transfer on ld_valid && ld_ready.
REQ-010 ld_rd  in  5  load destination register.
REQ-011 ld_data  in  XLEN  load result.
REQ-012 A3  out  5  register-file write address.
REQ-013 WD3  out  XLEN  register-file write data.
REQ-014 WE3  out  1  register-file write enable.
REQ-015 q_addr  in  5  bypass query address.
REQ-016 q_hit  out  1  pending/current write matches q_addr.
REQ-017 q_data  out  XLEN  bypass data.
REQ-018 pending  out  $clog2(DEPTH)+1  valid queue entries.

Function
REQ-019 Write port combinational: alu_valid && alu_rd!=0 -> A3=alu_rd, WD3=alu_data, WE3=1; else queue non-empty -> head drives A3/WD3, WE3=1, head pops at clock edge; else WE3=0, A3=0, WD3=0.
REQ-020 ALU always wins port; queue head waits, no starvation guarantee beyond ALU-idle cycles.
REQ-021 WE3 never asserted with A3=0; ALU writes to x0 ignored, leaving port free for queue head that cycle.
REQ-022 Load latency: accepted at edge N, earliest WE3 in cycle N+1 (no same-cycle pass-through).
REQ-023 Load with ld_rd=0 accepted (handshake completes) but not enqueued.
REQ-024 ld_ready = !full, from registered count only; pop in same cycle does not raise ld_ready.
REQ-025 Queue FIFO-ordered, circular pointers wrap mod DEPTH; simultaneous push and pop keeps count unchanged.
REQ-026 WAW kill: ALU write to rd (rd!=0) clears valid of every queued entry with same rd at that edge; killed entries skipped at head without WE3 and still freed.
REQ-027 Load accepted same cycle as ALU write to same rd is enqueued, not killed (load is younger).
REQ-028 pending counts live (unkilled) entries; full/empty use slot occupancy.

Reset
REQ-029 rst low: pointers, occupancy, valid bits cleared immediately; ld_ready=0, pending=0, q_hit=0, q_data=0 while asserted.
REQ-030 First edge after rst deasserts: ld_ready=1; in-flight entries lost, no partial writes.
REQ-031 Entry data storage not reset.

Configuration
REQ-032 Macro WB_BYPASS_EN defined: q_hit/q_data = ALU current write if alu_valid, alu_rd==q_addr!=0; else youngest live queued entry with rd==q_addr; else q_hit=0, q_data=0.
REQ-033 Macro undefined: ports present, q_hit=0, q_data=0 constant, no match logic.

Structure
REQ-034 Shared package wb_pkg: XLEN default, REG_ADDR_W=5, queue-entry struct {valid, rd, data}.
REQ-035 One sub-module wb_queue (circular buffer with kill and live-count); selection, WAW match, bypass in top.

Verification
REQ-036 Load rd=5 data=0x11 alone, ALU idle -> next cycle WE3=1, A3=5, WD3=0x11; pending 1->0.
REQ-037 Four loads rd=1..4 while ALU writes rd=9 each cycle -> ld_ready=0 after fourth, WE3 always for rd=9; ALU idle -> rd=1..4 written in order, one per cycle.
REQ-038 Queue load rd=7 data=0xAA, same cycle ALU rd=12; next cycle ALU rd=7 data=0xBB -> entry killed, rd=7 written once with 0xBB, never 0xAA.
REQ-039 ALU rd=0 data=0xFF with queued rd=3 -> WE3=1, A3=3; load rd=0 -> ld_ready handshake, pending unchanged.
REQ-040 WB_BYPASS_EN: queued rd=4 0x10 then 0x20, q_addr=4 -> q_hit=1, q_data=0x20; ALU rd=4 0x30 -> q_data=0x30; macro undefined -> q_hit=0.
REQ-041 rst low with 3 entries queued -> ld_ready=0, pending=0 immediately, no WE3 after release.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and queue-entry type for the writeback controller
package wb_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [DEF_XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - load-result circular buffer with WAW kill and live count
// WB_BYPASS_EN exposes slot contents and head pointer for the bypass search.
module wb_queue
    import wb_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [REG_ADDR_W-1:0]       push_rd,
    input  logic [XLEN-1:0]             push_data,
    input  logic                        pop,
    input  logic                        kill,
    input  logic [REG_ADDR_W-1:0]       kill_rd,
    output logic                        full,
    output logic                        empty,
    output wb_entry_t                   head,
`ifdef WB_BYPASS_EN
    output logic [$clog2(DEPTH)-1:0]    head_ptr,
    output wb_entry_t                   ents [DEPTH],
`endif
    output logic [$clog2(DEPTH):0]      live
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] hd;
    logic [AW-1:0] tl;
    logic [AW:0]   occ;

    // Only the valid bits carry reset; rd/data are don't-care until written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hd  <= '0;
            tl  <= '0;
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && mem[i].valid && mem[i].rd == kill_rd) mem[i].valid <= 1'b0;
            end
            if (pop) begin
                mem[hd].valid <= 1'b0;
                hd            <= hd + 1'b1;
            end
            // Push lands after the kill so a same-cycle younger load survives.
            if (push) begin
                mem[tl] <= '{valid: 1'b1, rd: push_rd, data: DEF_XLEN'(push_data)};
                tl      <= tl + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign full  = (occ == (AW+1)'(DEPTH));
    assign empty = (occ == '0);
    assign head  = mem[hd];

    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) live = live + (AW+1)'(mem[i].valid);
    end

`ifdef WB_BYPASS_EN
    assign head_ptr = hd;
    assign ents     = mem;
`endif

endmodule

// File: rtl/wb_ctrl.sv
// rtl/wb_ctrl.sv - register-file write-port arbiter for ALU and queued load results
// WB_BYPASS_EN enables the q_addr bypass search; otherwise q_hit/q_data stay zero.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [REG_ADDR_W-1:0]   alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [REG_ADDR_W-1:0]   ld_rd,
    input  logic [XLEN-1:0]         ld_data,
    output logic [REG_ADDR_W-1:0]   A3,
    output logic [XLEN-1:0]         WD3,
    output logic                    WE3,
    input  logic [REG_ADDR_W-1:0]   q_addr,
    output logic                    q_hit,
    output logic [XLEN-1:0]         q_data,
    output logic [$clog2(DEPTH):0]  pending
);

    localparam int AW = $clog2(DEPTH);

    logic      alu_we;
    logic      rdy_q;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    wb_entry_t head;

    assign alu_we   = alu_valid && (alu_rd != '0);
    assign ld_ready = rdy_q && !full;
    assign push     = ld_valid && ld_ready && (ld_rd != '0);
    // Killed heads drain even while the ALU holds the port; they need no write.
    assign pop      = !empty && (!head.valid || !alu_we);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy_q <= 1'b0;
        else      rdy_q <= 1'b1;
    end

`ifdef WB_BYPASS_EN
    logic [AW-1:0] head_ptr;
    wb_entry_t     ents [DEPTH];
`endif

    wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .pop       (pop),
        .kill      (alu_we),
        .kill_rd   (alu_rd),
        .full      (full),
        .empty     (empty),
        .head      (head),
`ifdef WB_BYPASS_EN
        .head_ptr  (head_ptr),
        .ents      (ents),
`endif
        .live      (pending)
    );

    always_comb begin
        WE3 = 1'b0;
        A3  = '0;
        WD3 = '0;
        if (alu_we) begin
            WE3 = 1'b1;
            A3  = alu_rd;
            WD3 = alu_data;
        end else if (head.valid) begin
            WE3 = 1'b1;
            A3  = head.rd;
            WD3 = XLEN'(head.data);
        end
    end

`ifdef WB_BYPASS_EN
    logic [AW-1:0] idx;

    // Walk oldest to youngest so the last match is the youngest live entry.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + AW'(i);
            if (ents[idx].valid && ents[idx].rd == q_addr) begin
                q_hit  = 1'b1;
                q_data = XLEN'(ents[idx].data);
            end
        end
        if (alu_we && alu_rd == q_addr) begin
            q_hit  = 1'b1;
            q_data = alu_data;
        end
        if (!rst) begin
            q_hit  = 1'b0;
            q_data = '0;
        end
    end
`else
    logic unused_q_addr;
    assign unused_q_addr = ^q_addr;
    assign q_hit         = 1'b0;
    assign q_data        = '0;
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// tb/tb_wb_ctrl.sv - directed scoreboard bench for wb_ctrl
module tb_wb_ctrl;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic [4:0]      A3;
    logic [XLEN-1:0] WD3;
    logic            WE3;
    logic [4:0]      q_addr;
    logic            q_hit;
    logic [XLEN-1:0] q_data;
    logic [PW-1:0]   pending;

    always #5 clk = ~clk;

    wb_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .A3(A3), .WD3(WD3), .WE3(WE3),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .pending(pending)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } ment_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    ment_t mq[$];
    wr_t   exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    rdy      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus: drive, predict, sample at +1, advance the model, wait for next negedge.
    task automatic cycle(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lr, input logic [31:0] ldd,
                         input logic [4:0] qa);
        bit          alu_we;
        bit          exp_rdy;
        bit          do_pop;
        bit          exp_hit;
        logic [31:0] exp_qd;
        int          live;
        wr_t         w;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_data = ldd; q_addr = qa;
        alu_we  = av && (ar != 5'd0);
        exp_rdy = rdy && (mq.size() < DEPTH);
        do_pop  = 1'b0;
        live    = 0;
        foreach (mq[i]) if (mq[i].live) live++;
        if (alu_we) exp_q.push_back('{ar, ad});
        if (mq.size() > 0) begin
            if (!mq[0].live) do_pop = 1'b1;
            else if (!alu_we) begin
                exp_q.push_back('{mq[0].rd, mq[0].data});
                do_pop = 1'b1;
            end
        end
        exp_hit = 1'b0;
        exp_qd  = 32'd0;
`ifdef WB_BYPASS_EN
        if (qa != 5'd0) begin
            foreach (mq[i]) if (mq[i].live && mq[i].rd == qa) begin
                exp_hit = 1'b1;
                exp_qd  = mq[i].data;
            end
            if (alu_we && ar == qa) begin
                exp_hit = 1'b1;
                exp_qd  = ad;
            end
        end
`endif
        #1;
        chk("ld_ready", 32'(ld_ready), 32'(exp_rdy));
        chk("pending", 32'(pending), 32'(live));
        chk("q_hit", 32'(q_hit), 32'(exp_hit));
        chk("q_data", q_data, exp_qd);
        if (WE3 === 1'b1) begin
            chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("A3", 32'(A3), 32'(w.rd));
                chk("WD3", WD3, w.data);
            end
        end
        chk("write_missing", 32'(exp_q.size()), 32'd0);
        exp_q = {};
        if (alu_we) foreach (mq[i]) if (mq[i].rd == ar) mq[i].live = 1'b0;
        if (do_pop) void'(mq.pop_front());
        if (lv && exp_rdy && lr != 5'd0) mq.push_back('{lr, ldd, 1'b1});
        rdy = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] qa);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa);
    endtask

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0; q_addr = '0;
        @(negedge clk); #1;
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_we3", 32'(WE3), 32'd0);
        chk("rst_q_hit", 32'(q_hit), 32'd0);
        chk("rst_q_data", q_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b0;
        idle(2, 5'd0);

        // Lone load: written the following cycle, pending 1 then 0.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11, 5'd0);
        #1;
        chk("ld5_we3", 32'(WE3), 32'd1);
        chk("ld5_a3", 32'(A3), 32'd5);
        chk("ld5_wd3", WD3, 32'h11);
        chk("ld5_pending1", 32'(pending), 32'd1);
        idle(1, 5'd0);
        #1;
        chk("ld5_pending0", 32'(pending), 32'd0);
        idle(1, 5'd0);

        // Fill the queue under continuous ALU traffic, then drain in order (pointers wrap).
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 5'd9, 32'h900 + 32'(i), 1'b1, 5'(i), 32'h100 + 32'(i), 5'd0);
        #1;
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        cycle(1'b1, 5'd9, 32'h905, 1'b1, 5'd7, 32'h77, 5'd0);
        idle(5, 5'd0);

        // WAW kill: queued rd7 overwritten by a later ALU write.
        cycle(1'b1, 5'd12, 32'hC, 1'b1, 5'd7, 32'hAA, 5'd0);
        cycle(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd0);
        idle(3, 5'd0);

        // ALU write to x0 leaves the port to the queue; load to x0 handshakes only.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 5'd0);
        cycle(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h44, 5'd0);
        idle(2, 5'd0);

        // Bypass: youngest queued entry, then the current ALU write.
        cycle(1'b1, 5'd12, 32'h1, 1'b1, 5'd4, 32'h10, 5'd4);
        cycle(1'b1, 5'd12, 32'h2, 1'b1, 5'd4, 32'h20, 5'd4);
        cycle(1'b1, 5'd12, 32'h3, 1'b0, 5'd0, 32'd0, 5'd4);
        cycle(1'b1, 5'd4, 32'h30, 1'b0, 5'd0, 32'd0, 5'd4);
        idle(3, 5'd4);

        // Reset with three entries in flight.
        for (int i = 1; i <= 3; i++)
            cycle(1'b1, 5'd12, 32'h20 + 32'(i), 1'b1, 5'(i), 32'h50 + 32'(i), 5'd2);
        alu_valid = 1'b0; alu_rd = '0; ld_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_we3", 32'(WE3), 32'd0);
        chk("mid_rst_q_hit", 32'(q_hit), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mq = {};
        rdy = 1'b0;
        idle(4, 5'd2);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
